uart_cmd_rx: RTL and testbench
==============================

# uart_cmd_rx

UART receive path and command-frame parser for the ADC/DAC board. It sits opposite the existing UART sample transmitter on the same serial link. It deserialises 8N1 bytes from the host at `UART_RATE` and assembles 4-byte command frames of the form header, address, data, checksum. On each valid frame it presents a one-cycle `cmd_valid` strobe with `cmd_addr`/`cmd_data`, which downstream logic uses for channel selection or DAC setpoints.

## Interface
- `CLK_FRE`, 50, input clock frequency in MHz.
- `UART_RATE`, 115200, baud rate.
- `HEADER`, 8'hA5, frame start byte.
- `TIMEOUT_BITS`, 20, inter-byte gap in bit periods that aborts a partial frame.
- `clk` in 1: system clock. One clock domain only.
- `rst` in 1: reset, asynchronous and active-high.
- `uart_rx` in 1: serial input, idle high, asynchronous to `clk`.
- `cmd_valid` out 1: one-cycle strobe for a good frame.
- `cmd_addr` out 8: address byte of the last good frame.
- `cmd_data` out 8: data byte of the last good frame.
- `frame_err` out 1: one-cycle strobe on a stop-bit error or checksum error.

## Operation
- **Synchroniser:** 2-FF synchroniser on `uart_rx`. Both flops reset to 1. All logic below uses the synchronised value `rx_s`.
- **Bit period:** BIT = CLK_FRE*1_000_000/UART_RATE, integer division (434 at the defaults). HALF = BIT/2 (217).
- **Byte FSM states:** IDLE, START, DATA, STOP.
  - IDLE: `rx_s` = 0 → START, bit counter cleared.
  - START: when counter = HALF-1, sample `rx_s`. If 1, the edge was a glitch → IDLE. If 0 → DATA, counter cleared.
  - DATA: sample every BIT cycles, LSB first, 8 bits → STOP.
  - STOP: sample after BIT cycles, at mid stop bit.
    - `rx_s` = 1 → internal `byte_stb` for one cycle with the byte.
    - `rx_s` = 0 → internal `stop_err` for one cycle, byte discarded.
    - Either way → IDLE immediately, half a bit early, so a back-to-back start bit is caught.
- **Parser states:** P_HDR, P_ADDR, P_DATA, P_SUM. It advances only on `byte_stb`.
  - P_HDR: byte = HEADER → P_ADDR. Any other byte is ignored silently.
  - P_ADDR: latch the address byte → P_DATA.
  - P_DATA: latch the data byte → P_SUM.
  - P_SUM: checksum = (HEADER + addr + data) mod 256.
    - Match → `cmd_valid`, and `cmd_addr`/`cmd_data` update in the same cycle.
    - Mismatch → `frame_err`.
    - Either way → P_HDR.
- **Error handling:**
  - `stop_err` in any parser state → `frame_err`, parser → P_HDR.
  - `stop_err` and the byte are never both asserted.
- **Timeout:** a gap counter runs while the parser is not in P_HDR and is cleared on each `byte_stb`. When it reaches TIMEOUT_BITS*BIT cycles, the parser → P_HDR silently, with no `frame_err`.
- **Output holding:** `cmd_addr`/`cmd_data` hold their values until the next good frame. A bad frame never alters them.

## Timing
- **Reset values:**
  - `cmd_valid` = 0, `frame_err` = 0, `cmd_addr` = 0, `cmd_data` = 0.
  - Byte FSM in IDLE, parser in P_HDR, all counters 0.
- **Reset mid-byte or mid-frame:** state is dropped with no strobe. After release, the block waits for the line idle (`rx_s` = 1 seen in IDLE) before accepting a start edge, so it does not lock onto a bit mid-byte.
- **Byte latency:** `byte_stb` occurs 2 + HALF + 9*BIT cycles after the pin's start falling edge, within ±2 cycles. At the defaults this is ≈4125 cycles.
- **Command latency:** `cmd_valid` and `frame_err` are registered. They assert 1 cycle after the `byte_stb` or `stop_err` of the deciding byte and last exactly 1 cycle.
- **Baud tolerance:** sampling at mid-bit tolerates ±2% baud mismatch over 10 bits.
- **Simultaneous events:** a timeout and a `byte_stb` in the same cycle give priority to the byte. The byte is processed in the current state and the gap counter is cleared.
- **Strobe spacing:** the minimum spacing between `cmd_valid` strobes is 4 byte times, i.e. 40*BIT.

## Test plan
- **Good frame:** send A5 03 7F 27 back-to-back at 115200 → exactly one `cmd_valid`, `cmd_addr` = 03, `cmd_data` = 7F, `frame_err` never asserted, strobe ≈4125 cycles after the checksum byte's start edge.
- **Bad checksum:** send A5 03 7F 28 → `frame_err` pulses once, no `cmd_valid`, outputs still hold their prior values. A following A5 01 02 A8 → `cmd_valid` with 01/02.
- **Stop-bit error:** stop bit forced low on the address byte → `frame_err`, parser resynchronises. The next correct frame is accepted.
- **Glitch and garbage:** a 100-cycle low pulse on idle `uart_rx`, then bytes 00 FF 12 with no header → no `byte_stb`/`cmd_valid`/`frame_err` from the glitch, garbage bytes ignored.
- **Timeout:** send A5 03, then idle for 25 bit periods, then 7F 27 → no `cmd_valid`, no `frame_err`. A subsequent full frame is accepted.
- **Reset mid-frame:** assert `rst` during the data byte → all outputs 0 immediately. After release, a complete frame A5 10 20 D5 → `cmd_valid` with 10/20.

Source files
------------

// File: rtl/uart_cmd_rx.sv
// UART 8N1 receiver plus header/addr/data/checksum command-frame parser.
// Emits a one-cycle cmd_valid per good frame and frame_err per bad one.
module uart_cmd_rx #(
    parameter int          CLK_FRE      = 50,
    parameter int          UART_RATE    = 115200,
    parameter logic [7:0]  HEADER       = 8'hA5,
    parameter int          TIMEOUT_BITS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       cmd_valid,
    output logic [7:0] cmd_addr,
    output logic [7:0] cmd_data,
    output logic       frame_err
);

    localparam int BIT  = CLK_FRE * 1_000_000 / UART_RATE;
    localparam int HALF = BIT / 2;
    localparam int TMO  = TIMEOUT_BITS * BIT;
    localparam int BW   = $clog2(BIT + 1);
    localparam int TW   = $clog2(TMO + 1);

    localparam logic [BW-1:0] BIT_END  = BW'(BIT - 1);
    localparam logic [BW-1:0] HALF_END = BW'(HALF - 1);
    localparam logic [TW-1:0] TMO_END  = TW'(TMO - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } bstate_t;

    typedef enum logic [1:0] {
        P_HDR,
        P_ADDR,
        P_DATA,
        P_SUM
    } pstate_t;

    logic          rx_m;
    logic          rx_s;
    logic [1:0]    settle;
    logic          armed;

    bstate_t       st;
    bstate_t       st_nx;
    logic [BW-1:0] bcnt;
    logic [2:0]    bidx;
    logic [7:0]    shreg;
    logic          bit_end;
    logic          half_end;
    logic          byte_stb;
    logic          stop_err;

    pstate_t       pst;
    pstate_t       pst_nx;
    logic [7:0]    addr_q;
    logic [7:0]    data_q;
    logic [7:0]    sum;
    logic [TW-1:0] gap;
    logic          timeout;
    logic          good_nx;
    logic          err_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= uart_rx;
            rx_s <= rx_m;
        end
    end

    // The synchroniser resets high, so only trust an idle line once it has flushed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle <= 2'd0;
            armed  <= 1'b0;
        end else begin
            if (settle != 2'd3)
                settle <= settle + 2'd1;
            if (settle == 2'd3 && rx_s)
                armed <= 1'b1;
        end
    end

    assign bit_end  = (bcnt == BIT_END);
    assign half_end = (bcnt == HALF_END);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            st <= S_IDLE;
        else
            st <= st_nx;
    end

    always_comb begin
        st_nx = st;
        unique case (st)
            S_IDLE:  if (armed && !rx_s) st_nx = S_START;
            S_START: if (half_end) st_nx = rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (bit_end && bidx == 3'd7) st_nx = S_STOP;
            S_STOP:  if (bit_end) st_nx = S_IDLE;
            default: st_nx = S_IDLE;
        endcase
    end

    always_comb begin
        byte_stb = 1'b0;
        stop_err = 1'b0;
        if (st == S_STOP && bit_end) begin
            byte_stb = rx_s;
            stop_err = !rx_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt  <= '0;
            bidx  <= 3'd0;
            shreg <= 8'd0;
        end else begin
            if (st != st_nx || (st == S_DATA && bit_end))
                bcnt <= '0;
            else if (st != S_IDLE)
                bcnt <= bcnt + 1'b1;
            if (st == S_START)
                bidx <= 3'd0;
            else if (st == S_DATA && bit_end)
                bidx <= bidx + 3'd1;
            if (st == S_DATA && bit_end)
                shreg <= {rx_s, shreg[7:1]};
        end
    end

    assign sum     = HEADER + addr_q + data_q;
    assign timeout = (pst != P_HDR) && (gap == TMO_END);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pst <= P_HDR;
        else
            pst <= pst_nx;
    end

    // A byte landing on the timeout cycle wins over the timeout.
    always_comb begin
        pst_nx = pst;
        if (stop_err) begin
            pst_nx = P_HDR;
        end else if (byte_stb) begin
            unique case (pst)
                P_HDR:   if (shreg == HEADER) pst_nx = P_ADDR;
                P_ADDR:  pst_nx = P_DATA;
                P_DATA:  pst_nx = P_SUM;
                P_SUM:   pst_nx = P_HDR;
                default: pst_nx = P_HDR;
            endcase
        end else if (timeout) begin
            pst_nx = P_HDR;
        end
    end

    always_comb begin
        good_nx = byte_stb && pst == P_SUM && shreg == sum;
        err_nx  = stop_err || (byte_stb && pst == P_SUM && shreg != sum);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= 8'd0;
            data_q    <= 8'd0;
            gap       <= '0;
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            cmd_addr  <= 8'd0;
            cmd_data  <= 8'd0;
        end else begin
            if (byte_stb && pst == P_ADDR)
                addr_q <= shreg;
            if (byte_stb && pst == P_DATA)
                data_q <= shreg;
            if (pst == P_HDR || byte_stb)
                gap <= '0;
            else if (!timeout)
                gap <= gap + 1'b1;
            cmd_valid <= good_nx;
            frame_err <= err_nx;
            if (good_nx) begin
                cmd_addr <= addr_q;
                cmd_data <= data_q;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: serial byte driver, frame-level reference model,
// per-cycle compare of strobes, strobe latency and held outputs.
module tb_uart_cmd_rx;

    localparam int         CLK_FRE = 50;
    localparam int         RATE    = 2_000_000;
    localparam int         BIT     = 25;
    localparam int         HALF    = 12;
    localparam int         TBITS   = 20;
    localparam logic [7:0] HDR     = 8'hA5;
    localparam int         LAT     = 3 + HALF + 9 * BIT;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rx;
    logic       cmd_valid;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       frame_err;

    uart_cmd_rx #(
        .CLK_FRE     (CLK_FRE),
        .UART_RATE   (RATE),
        .HEADER      (HDR),
        .TIMEOUT_BITS(TBITS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .uart_rx  (uart_rx),
        .cmd_valid(cmd_valid),
        .cmd_addr (cmd_addr),
        .cmd_data (cmd_data),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         err;
        logic [7:0] a;
        logic [7:0] d;
        int         t0;
    } ev_t;

    ev_t        expq[$];
    ev_t        ce;
    int         pos = 0;
    logic [7:0] m_a = 8'd0;
    logic [7:0] m_d = 8'd0;
    logic [7:0] held_a = 8'd0;
    logic [7:0] held_d = 8'd0;
    int         tests = 0;
    int         fails = 0;
    int         n_valid = 0;
    int         n_err = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame rules applied byte by byte; a long idle gap drops a partial frame.
    task automatic model_byte(input logic [7:0] b, input bit stop_ok,
                              input int gap, input int t0);
        ev_t e;
        if (gap >= 15)
            pos = 0;
        if (!stop_ok) begin
            e.err = 1'b1;
            e.a   = 8'd0;
            e.d   = 8'd0;
            e.t0  = t0;
            expq.push_back(e);
            pos = 0;
        end else begin
            case (pos)
                0: if (b == HDR) pos = 1;
                1: begin m_a = b; pos = 2; end
                2: begin m_d = b; pos = 3; end
                default: begin
                    e.err = (b != 8'(HDR + m_a + m_d));
                    e.a   = m_a;
                    e.d   = m_d;
                    e.t0  = t0;
                    expq.push_back(e);
                    pos = 0;
                end
            endcase
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap = 1,
                             input bit stop_ok = 1'b1);
        uart_rx = 1'b1;
        if (gap > 0)
            hold(gap * BIT);
        model_byte(b, stop_ok, gap, cyc);
        uart_rx = 1'b0;
        hold(BIT);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            hold(BIT);
        end
        if (stop_ok) begin
            uart_rx = 1'b1;
            hold(BIT);
        end else begin
            uart_rx = 1'b0;
            hold(HALF + 6);
            uart_rx = 1'b1;
            hold(2 * BIT - HALF - 6);
        end
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d,
                              input logic [7:0] s, input int gap);
        send_byte(HDR, gap);
        send_byte(a, gap);
        send_byte(d, gap);
        send_byte(s, gap);
    endtask

    always @(negedge clk) begin
        if (cmd_valid || frame_err) begin
            if (cmd_valid) n_valid++;
            if (frame_err) n_err++;
            tests++;
            if (expq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_strobe: valid=%0b err=%0b expected none",
                         cmd_valid, frame_err);
            end else begin
                ce = expq.pop_front();
                tests++;
                if (cmd_valid !== !ce.err || frame_err !== ce.err) begin
                    fails++;
                    $display("FAIL strobe_kind: valid=%0b err=%0b expected err=%0b",
                             cmd_valid, frame_err, ce.err);
                end
                tests++;
                if (cyc - ce.t0 - LAT > 2 || cyc - ce.t0 - LAT < -2) begin
                    fails++;
                    $display("FAIL latency: got %0d expected %0d +-2",
                             cyc - ce.t0, LAT);
                end
                if (!ce.err) begin
                    held_a = ce.a;
                    held_d = ce.d;
                end
            end
        end
        tests++;
        if (cmd_addr !== held_a || cmd_data !== held_d) begin
            fails++;
            $display("FAIL held_outputs: got %h/%h expected %h/%h",
                     cmd_addr, cmd_data, held_a, held_d);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int         v0;
        int         e0;
        int         k;
        int         j;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] fr[4];

        rst     = 1'b1;
        uart_rx = 1'b1;
        hold(5);
        chk("reset_valid", 32'(cmd_valid), 32'd0);
        chk("reset_err", 32'(frame_err), 32'd0);
        chk("reset_addr", 32'(cmd_addr), 32'd0);
        chk("reset_data", 32'(cmd_data), 32'd0);
        rst = 1'b0;
        hold(10);

        v0 = n_valid; e0 = n_err;
        send_frame(8'h03, 8'h7F, 8'h27, 0);
        hold(4);
        chk("good_count", 32'(n_valid - v0), 32'd1);
        chk("good_noerr", 32'(n_err - e0), 32'd0);
        chk("good_addr", 32'(cmd_addr), 32'h03);
        chk("good_data", 32'(cmd_data), 32'h7F);

        v0 = n_valid; e0 = n_err;
        send_frame(8'h03, 8'h7F, 8'h28, 1);
        hold(4);
        chk("badsum_err", 32'(n_err - e0), 32'd1);
        chk("badsum_novalid", 32'(n_valid - v0), 32'd0);
        chk("badsum_addr", 32'(cmd_addr), 32'h03);
        send_frame(8'h01, 8'h02, 8'hA8, 1);
        hold(4);
        chk("after_bad_addr", 32'(cmd_addr), 32'h01);
        chk("after_bad_data", 32'(cmd_data), 32'h02);

        v0 = n_valid; e0 = n_err;
        send_byte(HDR, 1);
        send_byte(8'h03, 0, 1'b0);
        send_frame(8'h22, 8'h33, 8'hFA, 1);
        hold(4);
        chk("stoperr_err", 32'(n_err - e0), 32'd1);
        chk("stoperr_resync", 32'(n_valid - v0), 32'd1);
        chk("stoperr_addr", 32'(cmd_addr), 32'h22);

        v0 = n_valid; e0 = n_err;
        uart_rx = 1'b0;
        hold(8);
        uart_rx = 1'b1;
        hold(3 * BIT);
        send_byte(8'h00, 1);
        send_byte(8'hFF, 1);
        send_byte(8'h12, 1);
        hold(4);
        chk("glitch_valid", 32'(n_valid - v0), 32'd0);
        chk("glitch_err", 32'(n_err - e0), 32'd0);

        v0 = n_valid; e0 = n_err;
        send_byte(HDR, 1);
        send_byte(8'h03, 0);
        send_byte(8'h7F, 25);
        send_byte(8'h27, 0);
        hold(4);
        chk("timeout_valid", 32'(n_valid - v0), 32'd0);
        chk("timeout_err", 32'(n_err - e0), 32'd0);
        send_frame(8'h44, 8'h55, 8'h3E, 1);
        hold(4);
        chk("after_to_addr", 32'(cmd_addr), 32'h44);
        chk("after_to_data", 32'(cmd_data), 32'h55);

        for (int s = 0; s < 12; s++) begin
            k     = $urandom_range(0, 3);
            a     = 8'($urandom);
            d     = 8'($urandom);
            fr[0] = HDR;
            fr[1] = a;
            fr[2] = d;
            fr[3] = 8'(HDR + a + d);
            case (k)
                0: send_frame(a, d, fr[3], $urandom_range(0, 3));
                1: send_frame(a, d, 8'(fr[3] + 8'($urandom_range(1, 255))),
                              $urandom_range(0, 3));
                2: begin
                    j = $urandom_range(0, 3);
                    for (int i = 0; i <= j; i++)
                        send_byte(fr[i], $urandom_range(0, 3), i != j);
                end
                default: begin
                    send_byte(8'($urandom), $urandom_range(0, 3));
                    send_byte(HDR, $urandom_range(0, 3));
                    send_byte(a, $urandom_range(0, 3));
                    send_byte(d, 25);
                end
            endcase
        end
        hold(3 * BIT);

        send_frame(8'h66, 8'h77, 8'h82, 2);
        hold(4);
        chk("pre_reset_addr", 32'(cmd_addr), 32'h66);
        send_byte(HDR, 1);
        send_byte(8'h10, 1);
        fork
            send_byte(8'h00, 1);
            begin
                hold(BIT * 4);
                rst = 1'b1;
                held_a = 8'd0;
                held_d = 8'd0;
                expq.delete();
                pos = 0;
                hold(1);
                chk("midrst_valid", 32'(cmd_valid), 32'd0);
                chk("midrst_err", 32'(frame_err), 32'd0);
                chk("midrst_addr", 32'(cmd_addr), 32'd0);
                chk("midrst_data", 32'(cmd_data), 32'd0);
                hold(3);
                rst = 1'b0;
            end
        join
        v0 = n_valid; e0 = n_err;
        send_frame(8'h10, 8'h20, 8'hD5, 2);
        hold(4);
        chk("post_rst_valid", 32'(n_valid - v0), 32'd1);
        chk("post_rst_noerr", 32'(n_err - e0), 32'd0);
        chk("post_rst_addr", 32'(cmd_addr), 32'h10);
        chk("post_rst_data", 32'(cmd_data), 32'h20);

        hold(4 * BIT);
        chk("pending_events", 32'(expq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
